// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory master: access sizes, FSM states,
// the registered command record and small decode helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE_ERR
    } state_e;

    typedef struct packed {
        logic        store;
        size_e       size;
        logic        sgn;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } cmd_t;

    // Counter counts 0 .. cycles-1, so it needs clog2(cycles) bits (at least one).
    function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && lane[0]) ||
               ((size == SZ_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Command/response port from the pipeline plus the req/ack memory port.
// master = the load/store unit, slave = pipeline and memory side.
interface lsu_mem_master_if;
    import lsu_pkg::*;

    logic        op_valid;
    logic        op_ready;
    logic        op_store;
    size_e       op_size;
    logic        op_signed;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;

    logic        done;
    logic [31:0] load_data;
    logic        misalign;
    logic        timeout;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  op_valid, op_store, op_size, op_signed, op_addr, op_wdata,
        input  mem_ack, mem_rdata,
        output op_ready, done, load_data, misalign, timeout,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output op_valid, op_store, op_size, op_signed, op_addr, op_wdata,
        output mem_ack, mem_rdata,
        input  op_ready, done, load_data, misalign, timeout,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_lane_unit.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; the caller samples the outputs when the read word is valid.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sgn,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        // Lane 0 is the most significant byte of the word.
        byte_sh = {~lane, 3'b000};
        half_sh = lane[1] ? 5'd0 : 5'd16;

        case (lane)
            2'd0:    ld_byte = rd_word[31:24];
            2'd1:    ld_byte = rd_word[23:16];
            2'd2:    ld_byte = rd_word[15:8];
            default: ld_byte = rd_word[7:0];
        endcase
        ld_half = lane[1] ? rd_word[15:0] : rd_word[31:16];

        load_data = rd_word;
        merged    = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sgn & ld_byte[7]}}, ld_byte};
                merged    = (rd_word & ~(32'h0000_00FF << byte_sh)) |
                            ({24'h0, wdata[7:0]} << byte_sh);
            end
            SZ_HALF: begin
                load_data = {{16{sgn & ld_half[15]}}, ld_half};
                merged    = (rd_word & ~(32'h0000_FFFF << half_sh)) |
                            ({16'h0, wdata[15:0]} << half_sh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one command at a time, single-cycle mem_req pulses, RMW for sub-word stores.
// Latency: load/word store done 2 cycles after acceptance, sub-word store 4, misaligned 0.
// Backpressure: op_ready only in IDLE; a silent memory is abandoned after TIMEOUT_CYCLES.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    lsu_mem_master_if.master  bus
);

    localparam int unsigned   CW   = timeout_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state;
    cmd_t          cmd;
    logic [CW-1:0] wait_cnt;
    logic          req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          done_q;
    logic          misalign_q;
    logic          timeout_q;
    logic [31:0]   ldata_q;
    logic [31:0]   ext_data;
    logic [31:0]   merged;

    lsu_lane_unit u_lane (
        .rd_word   (bus.mem_rdata),
        .wdata     (cmd.wdata),
        .lane      (cmd.lane),
        .size      (cmd.size),
        .sgn       (cmd.sgn),
        .load_data (ext_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd        <= '0;
            wait_cnt   <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            ldata_q    <= '0;
        end else begin
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        cmd <= '{store: bus.op_store, size: bus.op_size, sgn: bus.op_signed,
                                 lane: bus.op_addr[1:0], wdata: bus.op_wdata};
                        if (is_misaligned(bus.op_size, bus.op_addr[1:0])) begin
                            state      <= ST_DONE_ERR;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            addr_q <= {bus.op_addr[31:2], 2'b00};
                            req_q  <= 1'b1;
                            // Only full-word stores can skip the read half of the RMW.
                            if (bus.op_store && (bus.op_size == SZ_WORD)) begin
                                state   <= ST_WR_REQ;
                                we_q    <= 1'b1;
                                wdata_q <= bus.op_wdata;
                            end else begin
                                state <= ST_RD_REQ;
                                we_q  <= 1'b0;
                            end
                        end
                    end
                end
                ST_RD_REQ: begin
                    state    <= ST_RD_WAIT;
                    wait_cnt <= '0;
                end
                ST_WR_REQ: begin
                    state    <= ST_WR_WAIT;
                    wait_cnt <= '0;
                    we_q     <= 1'b0;
                end
                ST_RD_WAIT: begin
                    if (bus.mem_ack) begin
                        if (cmd.store) begin
                            state   <= ST_WR_REQ;
                            req_q   <= 1'b1;
                            we_q    <= 1'b1;
                            wdata_q <= merged;
                        end else begin
                            state   <= ST_IDLE;
                            done_q  <= 1'b1;
                            ldata_q <= ext_data;
                        end
                    end else if (wait_cnt == LAST) begin
                        state     <= ST_IDLE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_WR_WAIT: begin
                    if (bus.mem_ack) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else if (wait_cnt == LAST) begin
                        state     <= ST_IDLE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_DONE_ERR: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    assign bus.op_ready  = (state == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.misalign  = misalign_q;
    assign bus.timeout   = timeout_q;
    assign bus.load_data = ldata_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: per-command timeline model checked every cycle,
// plus literal checks of results, memory contents and request counts.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_master_if bus ();

    lsu_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rd_cnt      = 0;
    int wr_cnt      = 0;
    logic ack_en    = 1'b1;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    // Expected timeline of the command in flight, relative to its acceptance edge.
    logic        active = 1'b0;
    int          e0 = 0;
    int          done_k = 0;
    logic        m_err, m_sub, m_to, m_ldok, m_we0;
    logic [31:0] m_addr, m_wd, m_merged, m_result;
    logic [31:0] ld_hold;

    task automatic check_b(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %b, required %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a,
                                           input size_e sz, input logic sg);
        logic [7:0]  b [4];
        logic [31:0] x;
        b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
        if (sz == SZ_BYTE) begin
            x = {24'h0, b[a]};
            if (sg && x[7]) x = x - 32'h100;
            return x;
        end
        if (sz == SZ_HALF) begin
            x = {16'h0, b[{a[1], 1'b0}], b[{a[1], 1'b1}]};
            if (sg && x[15]) x = x - 32'h1_0000;
            return x;
        end
        return w;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [1:0] a, input size_e sz);
        logic [7:0] b [4];
        b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
        if (sz == SZ_BYTE) begin
            b[a] = wd[7:0];
        end else if (sz == SZ_HALF) begin
            b[{a[1], 1'b0}] = wd[15:8];
            b[{a[1], 1'b1}] = wd[7:0];
        end else begin
            return wd;
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder: samples req on an edge, acks during the following cycle.
    initial begin
        logic        hit;
        logic [31:0] rd;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            hit = 1'b0;
            rd  = 32'h0;
            if (bus.mem_req === 1'b1) begin
                if (bus.mem_we) wr_cnt++;
                else            rd_cnt++;
                if (ack_en) begin
                    hit = 1'b1;
                    if (bus.mem_we) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
                    rd = mem[bus.mem_addr[7:2]];
                end
            end
            #1;
            bus.mem_ack   = hit;
            bus.mem_rdata = hit ? rd : 32'h5A5A_5A5A;
        end
    end

    // Per-cycle compare against the timeline model.
    int          k;
    logic        in_op, e_done, e_req, e_rdy;
    logic [31:0] e_ld;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            ld_hold = 32'h0;
        end else begin
            k      = cyc - e0;
            in_op  = active && (k >= 0) && (k <= done_k);
            e_done = in_op && (k == done_k);
            e_req  = in_op && !m_err && ((k == 0) || (m_sub && !m_to && (k == 2)));
            e_rdy  = !in_op || (e_done && !m_err);
            e_ld   = (e_done && m_ldok) ? m_result : ld_hold;
            check_b("done", bus.done, e_done);
            check_b("misalign", bus.misalign, e_done && m_err);
            check_b("timeout", bus.timeout, e_done && m_to);
            check_b("mem_req", bus.mem_req, e_req);
            check_b("op_ready", bus.op_ready, e_rdy);
            check_w("load_data", bus.load_data, e_ld);
            if (e_req) begin
                check_w("mem_addr", bus.mem_addr, m_addr);
                check_b("mem_we", bus.mem_we, (k == 0) ? m_we0 : 1'b1);
                if ((k == 0) && m_we0) check_w("mem_wdata", bus.mem_wdata, m_wd);
                if (k == 2)            check_w("mem_wdata_rmw", bus.mem_wdata, m_merged);
            end
            ld_hold = e_ld;
        end
    end

    task automatic preload(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    task automatic issue(input logic st, input size_e sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic noack);
        int          guard;
        logic [31:0] w;
        guard = 0;
        while (bus.op_ready !== 1'b1 && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        if (bus.op_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL op_ready_wait: got %b, required 1", bus.op_ready);
        end
        w        = ref_mem[a[7:2]];
        m_err    = (sz == SZ_ILL) || ((sz == SZ_HALF) && a[0]) ||
                   ((sz == SZ_WORD) && (a[1:0] != 2'b00));
        m_sub    = st && ((sz == SZ_BYTE) || (sz == SZ_HALF));
        m_to     = noack && !m_err;
        m_ldok   = !st && !m_err && !noack;
        m_we0    = st && !m_sub;
        m_addr   = {a[31:2], 2'b00};
        m_wd     = wd;
        m_merged = m_merge(w, wd, a[1:0], sz);
        m_result = m_load(w, a[1:0], sz, sg);
        done_k   = m_err ? 0 : (noack ? 1 + TO : (m_sub ? 4 : 2));
        if (st && !m_err && !noack) ref_mem[a[7:2]] = m_sub ? m_merged : wd;
        ack_en = !noack;
        e0     = cyc + 1;
        active = 1'b1;
        bus.op_valid  = 1'b1;
        bus.op_store  = st;
        bus.op_size   = sz;
        bus.op_signed = sg;
        bus.op_addr   = a;
        bus.op_wdata  = wd;
        @(posedge clk); #1;
        // Scramble the fields so anything not registered at acceptance shows up.
        bus.op_valid  = 1'b0;
        bus.op_store  = ~st;
        bus.op_size   = SZ_ILL;
        bus.op_signed = ~sg;
        bus.op_addr   = 32'hFFFF_FFFF;
        bus.op_wdata  = 32'h0BAD_F00D;
    endtask

    task automatic run_op(input logic st, input size_e sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic noack);
        issue(st, sz, sg, a, wd, noack);
        repeat (done_k + 1) @(posedge clk);
        #1;
    endtask

    int          rd0, wr0;
    logic [31:0] saved;

    initial begin
        rst           = 1'b1;
        bus.op_valid  = 1'b0;
        bus.op_store  = 1'b0;
        bus.op_size   = SZ_BYTE;
        bus.op_signed = 1'b0;
        bus.op_addr   = 32'h0;
        bus.op_wdata  = 32'h0;
        for (int i = 0; i < 64; i++) preload(i, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        check_b("rst_op_ready", bus.op_ready, 1'b1);
        check_b("rst_mem_req", bus.mem_req, 1'b0);
        check_b("rst_mem_we", bus.mem_we, 1'b0);
        check_b("rst_done", bus.done, 1'b0);
        check_b("rst_misalign", bus.misalign, 1'b0);
        check_b("rst_timeout", bus.timeout, 1'b0);
        check_w("rst_mem_addr", bus.mem_addr, 32'h0);
        check_w("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check_w("rst_load_data", bus.load_data, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word load
        preload(16, 32'hDEAD_BEEF);
        rd0 = rd_cnt; wr0 = wr_cnt;
        run_op(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0);
        check_w("lw_data", bus.load_data, 32'hDEAD_BEEF);
        check_w("lw_rd_reqs", 32'(rd_cnt - rd0), 32'd1);
        check_w("lw_wr_reqs", 32'(wr_cnt - wr0), 32'd0);

        // Sub-word loads, both extensions
        preload(16, 32'h1122_33F4);
        preload(17, 32'h8001_7FFF);
        run_op(1'b0, SZ_BYTE, 1'b1, 32'h43, 32'h0, 1'b0);
        check_w("lb_43_s", bus.load_data, 32'hFFFF_FFF4);
        run_op(1'b0, SZ_BYTE, 1'b0, 32'h43, 32'h0, 1'b0);
        check_w("lbu_43", bus.load_data, 32'h0000_00F4);
        run_op(1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0, 1'b0);
        check_w("lh_42_s", bus.load_data, 32'h0000_33F4);
        run_op(1'b0, SZ_HALF, 1'b0, 32'h40, 32'h0, 1'b0);
        check_w("lhu_40", bus.load_data, 32'h0000_1122);
        run_op(1'b0, SZ_HALF, 1'b1, 32'h44, 32'h0, 1'b0);
        check_w("lh_44_s", bus.load_data, 32'hFFFF_8001);
        run_op(1'b0, SZ_BYTE, 1'b1, 32'h46, 32'h0, 1'b0);
        check_w("lb_46_s", bus.load_data, 32'h0000_007F);
        run_op(1'b0, SZ_WORD, 1'b1, 32'h44, 32'h0, 1'b0);
        check_w("lw_44_signed_ignored", bus.load_data, 32'h8001_7FFF);

        // Read-modify-write stores and a plain word store
        preload(16, 32'h1122_3344);
        rd0 = rd_cnt; wr0 = wr_cnt;
        run_op(1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h0000_00AB, 1'b0);
        check_w("sb_rd_reqs", 32'(rd_cnt - rd0), 32'd1);
        check_w("sb_wr_reqs", 32'(wr_cnt - wr0), 32'd1);
        check_w("sb_mem", mem[16], 32'h11AB_3344);
        run_op(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0);
        check_w("lw_after_sb", bus.load_data, 32'h11AB_3344);
        run_op(1'b1, SZ_HALF, 1'b1, 32'h42, 32'h1234_CAFE, 1'b0);
        check_w("sh_mem", mem[16], 32'h11AB_CAFE);
        rd0 = rd_cnt; wr0 = wr_cnt;
        run_op(1'b1, SZ_WORD, 1'b0, 32'h44, 32'hA5A5_0001, 1'b0);
        check_w("sw_mem", mem[17], 32'hA5A5_0001);
        check_w("sw_rd_reqs", 32'(rd_cnt - rd0), 32'd0);
        check_w("sw_wr_reqs", 32'(wr_cnt - wr0), 32'd1);

        // Misaligned and illegal commands: no memory traffic, load_data held
        rd0 = rd_cnt; wr0 = wr_cnt;
        run_op(1'b0, SZ_WORD, 1'b0, 32'h42, 32'h0, 1'b0);
        run_op(1'b1, SZ_HALF, 1'b0, 32'h41, 32'hFFFF, 1'b0);
        run_op(1'b0, SZ_ILL, 1'b0, 32'h40, 32'h0, 1'b0);
        run_op(1'b1, SZ_WORD, 1'b0, 32'h41, 32'h1, 1'b0);
        check_w("mis_reqs", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
        check_w("mis_load_data", bus.load_data, 32'h11AB_3344);
        check_w("mis_mem", mem[16], 32'h11AB_CAFE);

        // Silent memory: RMW read and word write both abandoned
        preload(18, 32'hCAFE_BABE);
        rd0 = rd_cnt; wr0 = wr_cnt;
        run_op(1'b1, SZ_BYTE, 1'b0, 32'h48, 32'h55, 1'b1);
        check_w("to_sb_rd_reqs", 32'(rd_cnt - rd0), 32'd1);
        check_w("to_sb_wr_reqs", 32'(wr_cnt - wr0), 32'd0);
        run_op(1'b1, SZ_WORD, 1'b0, 32'h48, 32'h1, 1'b1);
        check_w("to_sw_wr_reqs", 32'(wr_cnt - wr0), 32'd1);
        check_w("to_mem", mem[18], 32'hCAFE_BABE);

        // Reset while the RMW read waits for its ack (ack still in flight afterwards)
        saved = ref_mem[16];
        wr0   = wr_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h40, 32'h77, 1'b0);
        @(posedge clk);
        #2;
        active = 1'b0;
        rst    = 1'b1;
        #1;
        check_b("midrst_mem_req", bus.mem_req, 1'b0);
        check_b("midrst_op_ready", bus.op_ready, 1'b1);
        check_b("midrst_done", bus.done, 1'b0);
        check_w("midrst_load_data", bus.load_data, 32'h0);
        #1;
        rst = 1'b0;
        ref_mem[16] = saved;
        repeat (6) @(posedge clk);
        #1;
        check_w("midrst_wr_reqs", 32'(wr_cnt - wr0), 32'd0);
        check_w("midrst_mem", mem[16], 32'h11AB_CAFE);
        run_op(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0);
        check_w("lw_after_rst", bus.load_data, 32'h11AB_CAFE);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
